clb_cluster: RTL and testbench
==============================

# clb_cluster

Parametrised configurable logic cluster: N basic logic elements (BLEs), each a K-input LUT, a D flip-flop with configurable init value and a LUT/FF output select, all programmed through one serial configuration chain. Configuration and user logic share a single clock. A load-tracking state machine gates outputs until a complete frame has been shifted in and flags short loads. Clusters daisy-chain through `prog_in`/`prog_out` to form a fabric column.

## Interface
- `K`, 4: LUT inputs per BLE; LUT table size is 2^K bits.
- `N`, 2: BLEs per cluster.
- `SHIFT_DIR`, 0: 0 = bits enter at chain MSB and exit at bit 0; 1 = bits enter at bit 0 and exit at MSB.
- Derived: `W = 2^K + 2` bits per BLE; `CFG_BITS = N*W`.

- `clb_clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `prog_en`  in  1  configuration shift enable.
- `prog_in`  in  1  serial configuration data in.
- `prog_out`  out  1  serial data out: the chain bit at the exit end.
- `clb_ce`  in  1  FF clock enable while in RUN.
- `clb_input`  in  N*K  BLE i uses bits `[i*K +: K]`.
- `clb_output`  out  N  BLE i result on bit i.
- `cfg_done`  out  1  high while in RUN.
- `cfg_err`  out  1  one-cycle pulse on an incomplete load.

## Operation
- Chain `cfg[CFG_BITS-1:0]`. BLE i frame is `cfg[i*W +: W]`.
  - Bit 0 is the output select: 0 = LUT, 1 = FF.
  - Bit 1 is the FF init value.
  - Bits `[2 +: 2^K]` are the LUT table.
- LUT output is `table[clb_input[i*K +: K]]`, with the index treated as unsigned.
- Shift, on each cycle with `prog_en` high:
  - SHIFT_DIR=0: `cfg <= {prog_in, cfg[CFG_BITS-1:1]}`, and `prog_out = cfg[0]`.
  - SHIFT_DIR=1: `cfg <= {cfg[CFG_BITS-2:0], prog_in}`, and `prog_out = cfg[CFG_BITS-1]`.
- Bit counter `cnt` is wide enough for CFG_BITS. It counts shifted bits and saturates at CFG_BITS.
- States: UNCONF, LOAD, RUN. Transitions by current state:
  - UNCONF, `prog_en`=1: go to LOAD, `cnt <= 1`, shift.
  - LOAD, `prog_en`=1: stay in LOAD, shift, increment `cnt` (saturating).
  - LOAD, `prog_en`=0 and `cnt == CFG_BITS`: go to RUN. Every BLE FF loads its init bit this cycle.
  - LOAD, `prog_en`=0 and `cnt < CFG_BITS`: go to UNCONF and pulse `cfg_err` for 1 cycle.
  - RUN, `prog_en`=1: go to LOAD (reconfiguration), `cnt <= 1`, shift.
- Over-shifting (more than CFG_BITS bits) is legal. The last CFG_BITS bits win and the load counts as complete.
- FFs:
  - In RUN with `clb_ce`=1, each FF captures its LUT output.
  - In RUN with `clb_ce`=0, each FF holds.
  - Outside RUN, FFs hold, except for the init load on the LOAD->RUN transition.
- `clb_output[i]` is the BLE i selected source in RUN, and 0 in any other state.
- Reset (wins over `prog_en`):
  - `cfg` = 0, `cnt` = 0, state = UNCONF, all FFs = 0.
  - `cfg_done` = 0, `cfg_err` = 0, `clb_output` = 0, `prog_out` = 0.
- Reset asserted mid-load aborts the load with no `cfg_err` pulse.

## Timing
- `prog_out` is a chain register bit. A bit presented on `prog_in` appears on `prog_out` CFG_BITS cycles later with `prog_en` held high. Chained clusters therefore add their CFG_BITS lengths.
- `cfg_done` rises in the cycle after the `prog_en` falling edge that closes a complete load. It falls in the cycle after `prog_en` rises again.
- `cfg_err` is high for exactly the one cycle after a short-load `prog_en` falling edge.
- LUT-select path: `clb_input` to `clb_output` is combinational, 0 cycles.
- FF-select path: 1 cycle from `clb_input` to `clb_output`.
- The first output in RUN on the FF path is the init value. The first LUT capture happens on the first RUN edge with `clb_ce`=1.
- There is no output glitch protection during reconfiguration. Outputs are forced to 0 from the first LOAD cycle.

## Test plan
- Complete load, LUT path. K=4, N=2, CFG_BITS=36.
  - Stimulus: shift 36 bits giving BLE0 table 0x8000 (AND4) with sel=0, and BLE1 table 0xFFFE (OR4) with sel=0; then drop `prog_en`.
  - Required: next cycle `cfg_done`=1; `clb_input`=8'hF0 gives `clb_output`=2'b10; `clb_input`=8'hFF gives 2'b11.
- FF path and init.
  - Stimulus: BLE0 sel=1, init=1, table 0x5555.
  - Required: first RUN cycle `clb_output[0]`=1. With `clb_ce`=1 and input 4'h1 (LUT output 0): output 0 one cycle later. With `clb_ce`=0: output holds.
- Short load.
  - Stimulus: shift 20 bits, then drop `prog_en`.
  - Required: `cfg_err` is a 1-cycle pulse, `cfg_done` stays 0, `clb_output` stays 0.
- Chaining and SHIFT_DIR.
  - Stimulus: two clusters, one per SHIFT_DIR; shift 72 bits.
  - Required: the first bit of the stream emerges on the second cluster's `prog_out` at cycle 72; both clusters match the golden frame.
- Reconfiguration and reset mid-load.
  - Stimulus: from RUN, raise `prog_en`, then assert `rst` after 10 bits.
  - Required: outputs are 0 from the first LOAD cycle; after `rst`, all outputs and `cnt` are 0 with no `cfg_err`; a subsequent full load succeeds.
- Over-shift.
  - Stimulus: shift 40 bits.
  - Required: RUN is entered; the configuration equals the last 36 bits.

Source files
------------

// File: rtl/clb_cluster.sv
// Configurable logic cluster: N K-input LUT/FF logic elements programmed through one serial chain,
// with a load-tracking FSM that gates outputs until a complete frame is present.
module clb_cluster #(
  parameter int K         = 4,
  parameter int N         = 2,
  parameter int SHIFT_DIR = 0
) (
  input  logic         clb_clk,
  input  logic         rst,
  input  logic         prog_en,
  input  logic         prog_in,
  output logic         prog_out,
  input  logic         clb_ce,
  input  logic [N*K-1:0] clb_input,
  output logic [N-1:0] clb_output,
  output logic         cfg_done,
  output logic         cfg_err
);

  localparam int W        = 2**K + 2;
  localparam int CFG_BITS = N * W;
  localparam int CW       = $clog2(CFG_BITS + 1);
  localparam logic [CW-1:0] FULL = CW'(CFG_BITS);

  typedef enum logic [1:0] {UNCONF, LOAD, RUN} state_e;

  state_e              state_q;
  logic [CFG_BITS-1:0] cfg_q, cfg_d;
  logic [CW-1:0]       cnt_q;
  logic [N-1:0]        ff_q;
  logic                err_q;
  logic [N-1:0]        sel, init, lut_out;

  if (SHIFT_DIR == 0) begin : g_dir_msb_in
    assign cfg_d    = {prog_in, cfg_q[CFG_BITS-1:1]};
    assign prog_out = cfg_q[0];
  end else begin : g_dir_lsb_in
    assign cfg_d    = {cfg_q[CFG_BITS-2:0], prog_in};
    assign prog_out = cfg_q[CFG_BITS-1];
  end

  // Each frame: bit 0 output select, bit 1 FF init, then the 2^K-entry truth table.
  for (genvar i = 0; i < N; i++) begin : g_ble
    logic [2**K-1:0] lut_tbl;
    assign lut_tbl    = cfg_q[i*W+2 +: 2**K];
    assign sel[i]     = cfg_q[i*W];
    assign init[i]    = cfg_q[i*W+1];
    assign lut_out[i] = lut_tbl[clb_input[i*K +: K]];
  end

  always_ff @(posedge clb_clk) begin
    if (rst) begin
      // NOTE: the configuration chain is reset too, so prog_out reads 0 out of reset and a
      // downstream cluster never shifts in X.
      state_q <= UNCONF;
      cnt_q   <= '0;
      cfg_q   <= '0;
      ff_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only here, so every branch sees the pre-edge state.
      err_q <= 1'b0;
      if (prog_en) cfg_q <= cfg_d;
      case (state_q)
        UNCONF: begin
          if (prog_en) begin
            state_q <= LOAD;
            cnt_q   <= CW'(1);
          end
        end
        LOAD: begin
          if (prog_en) begin
            if (cnt_q != FULL) cnt_q <= cnt_q + 1'b1;
          end else if (cnt_q == FULL) begin
            state_q <= RUN;
            ff_q    <= init;
          end else begin
            state_q <= UNCONF;
            err_q   <= 1'b1;
          end
        end
        RUN: begin
          if (prog_en) begin
            state_q <= LOAD;
            cnt_q   <= CW'(1);
          end else if (clb_ce) begin
            ff_q <= lut_out;
          end
        end
        default: state_q <= UNCONF;
      endcase
    end
  end

  assign cfg_done   = (state_q == RUN);
  assign cfg_err    = err_q;
  assign clb_output = cfg_done ? ((sel & ff_q) | (~sel & lut_out)) : '0;

endmodule

// File: tb/tb_clb_cluster.sv
// Two chained clusters (SHIFT_DIR 0 feeding SHIFT_DIR 1) checked against a queue-based model of
// the 72-bit chain plus per-cluster load/run bookkeeping.
module tb_clb_cluster;

  localparam int K  = 4;
  localparam int N  = 2;
  localparam int W  = 18;
  localparam int CB = 36;
  localparam int NK = N * K;

  logic          clk = 1'b0;
  logic          rst, prog_en, prog_in, clb_ce;
  logic [NK-1:0] clb_input;
  logic          po0, po1, done0, done1, err0, err1;
  logic [N-1:0]  out0, out1;

  int n_cmp = 0;
  int n_err = 0;

  // Model: whole chain as a FIFO, front = oldest bit (at dut1's exit end).
  bit chain_q[$];
  int mode[2];   // 0 unconfigured, 1 loading, 2 running
  int nbits[2];
  bit ff_m[2][N];
  bit err_m[2];

  bit s[2*CB];
  bit r40[40];

  always #5 clk = ~clk;

  clb_cluster #(.K(K), .N(N), .SHIFT_DIR(0)) dut0 (
    .clb_clk(clk), .rst(rst), .prog_en(prog_en), .prog_in(prog_in), .prog_out(po0),
    .clb_ce(clb_ce), .clb_input(clb_input), .clb_output(out0), .cfg_done(done0), .cfg_err(err0)
  );

  clb_cluster #(.K(K), .N(N), .SHIFT_DIR(1)) dut1 (
    .clb_clk(clk), .rst(rst), .prog_en(prog_en), .prog_in(po0), .prog_out(po1),
    .clb_ce(clb_ce), .clb_input(clb_input), .clb_output(out1), .cfg_done(done1), .cfg_err(err1)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Cluster 0 holds the newest 36 bits with the oldest at bit 0; cluster 1 holds the older
  // 36 with the oldest at its MSB.
  function automatic bit fbit(int c, int j);
    return (c == 0) ? chain_q[CB + j] : chain_q[CB - 1 - j];
  endfunction

  function automatic bit exp_lut(int c, int i);
    int idx;
    idx = int'(clb_input[i*K +: K]);
    return fbit(c, i*W + 2 + idx);
  endfunction

  function automatic bit exp_out(int c, int i);
    if (mode[c] != 2) return 1'b0;
    return fbit(c, i*W) ? ff_m[c][i] : exp_lut(c, i);
  endfunction

  task automatic model_edge();
    if (rst) begin
      chain_q.delete();
      for (int j = 0; j < 2*CB; j++) chain_q.push_back(1'b0);
      for (int c = 0; c < 2; c++) begin
        mode[c] = 0; nbits[c] = 0; err_m[c] = 1'b0;
        for (int i = 0; i < N; i++) ff_m[c][i] = 1'b0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        err_m[c] = 1'b0;
        if (prog_en) begin
          if (mode[c] != 1) nbits[c] = 0;
          nbits[c]++;
          mode[c] = 1;
        end else if (mode[c] == 1) begin
          if (nbits[c] >= CB) begin
            mode[c] = 2;
            for (int i = 0; i < N; i++) ff_m[c][i] = fbit(c, i*W + 1);
          end else begin
            mode[c] = 0;
            err_m[c] = 1'b1;
          end
        end else if (mode[c] == 2 && clb_ce) begin
          for (int i = 0; i < N; i++) ff_m[c][i] = exp_lut(c, i);
        end
      end
      if (prog_en) begin
        void'(chain_q.pop_front());
        chain_q.push_back(prog_in);
      end
    end
  endtask

  task automatic check_all();
    logic [N-1:0] e0, e1;
    for (int i = 0; i < N; i++) begin
      e0[i] = exp_out(0, i);
      e1[i] = exp_out(1, i);
    end
    check("out0",  8'(out0),  8'(e0));
    check("out1",  8'(out1),  8'(e1));
    check("done0", 8'(done0), 8'(mode[0] == 2));
    check("done1", 8'(done1), 8'(mode[1] == 2));
    check("err0",  8'(err0),  8'(err_m[0]));
    check("err1",  8'(err1),  8'(err_m[1]));
    check("pout0", 8'(po0),   8'(chain_q[CB]));
    check("pout1", 8'(po1),   8'(chain_q[0]));
  endtask

  task automatic cyc(input bit r, input bit en, input bit din, input bit ce,
                     input logic [NK-1:0] inp);
    @(negedge clk);
    rst = r; prog_en = en; prog_in = din; clb_ce = ce; clb_input = inp;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic load36(input logic [CB-1:0] f);
    for (int j = 0; j < CB; j++) cyc(1'b0, 1'b1, f[j], 1'b0, 8'h00);
  endtask

  initial begin
    logic [CB-1:0] f1, f2;
    int len;
    int idx;
    rst = 1'b1; prog_en = 1'b0; prog_in = 1'b0; clb_ce = 1'b0; clb_input = '0;
    f1 = {16'hFFFE, 2'b00, 16'h8000, 2'b00};
    f2 = {16'hA5A5, 2'b00, 16'h5555, 2'b11};

    // Reset state
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
    check("rst_out",  8'(out0),  8'h00);
    check("rst_done", 8'(done0), 8'h00);
    check("rst_pout", 8'(po0),   8'h00);

    // Complete load: AND4 on BLE0, OR4 on BLE1, LUT path
    load36(f1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'hF0);
    check("t1_done",  8'(done0), 8'h01);
    check("t1_in_F0", 8'(out0),  8'h02);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
    check("t1_in_FF", 8'(out0),  8'h03);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("t1_in_00", 8'(out0),  8'h00);

    // Reconfigure to FF path with init=1
    cyc(1'b0, 1'b1, f2[0], 1'b0, 8'hFF);
    check("reconf_out0",  8'(out0),  8'h00);
    check("reconf_done0", 8'(done0), 8'h00);
    for (int j = 1; j < CB; j++) cyc(1'b0, 1'b1, f2[j], 1'b0, 8'h01);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h01);
    check("ff_init", 8'(out0[0]), 8'h01);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h01);
    check("ff_capture0", 8'(out0[0]), 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("ff_hold", 8'(out0[0]), 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check("ff_capture1", 8'(out0[0]), 8'h01);

    // Short load of 20 bits
    for (int j = 0; j < 20; j++) cyc(1'b0, 1'b1, 1'($urandom), 1'b0, 8'($urandom));
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
    check("short_err",  8'(err0),  8'h01);
    check("short_done", 8'(done0), 8'h00);
    check("short_out",  8'(out0),  8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
    check("short_err_fall", 8'(err0),  8'h00);
    check("short_done2",    8'(done0), 8'h00);

    // Chained clusters, 72-bit stream, then read the chain back out
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int j = 0; j < 2*CB; j++) s[j] = 1'($urandom);
    for (int j = 0; j < 2*CB; j++) begin
      cyc(1'b0, 1'b1, s[j], 1'b0, 8'($urandom));
      if (j == 2*CB - 2) check("chain_early", 8'(po1), 8'h00);
    end
    check("chain_first_bit", 8'(po1), 8'(s[0]));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom));
    check("chain_done0", 8'(done0), 8'h01);
    check("chain_done1", 8'(done1), 8'h01);
    for (int j = 0; j < 40; j++) cyc(1'b0, 1'b0, 1'b0, 1'($urandom), 8'($urandom));
    for (int j = 1; j < 2*CB; j++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'($urandom));
      check("chain_readback", 8'(po1), 8'(s[j]));
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Reconfiguration aborted by reset after 10 bits
    for (int j = 0; j < 10; j++) begin
      cyc(1'b0, 1'b1, 1'($urandom), 1'b1, 8'hFF);
      if (j == 0) check("abort_out_first_load", 8'(out0), 8'h00);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
    check("abort_out",  8'(out0),  8'h00);
    check("abort_err",  8'(err0),  8'h00);
    check("abort_pout", 8'(po1),   8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
    check("abort_no_err",  8'(err0),  8'h00);
    check("abort_no_done", 8'(done0), 8'h00);
    load36(f1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'hF0);
    check("reload_done", 8'(done0), 8'h01);
    check("reload_out",  8'(out0),  8'h02);

    // Over-shift by 4: the last 36 bits form the frame (select bits forced to LUT)
    for (int j = 0; j < 40; j++) r40[j] = 1'($urandom);
    r40[4] = 1'b0;
    r40[4 + W] = 1'b0;
    for (int j = 0; j < 40; j++) cyc(1'b0, 1'b1, r40[j], 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("over_done", 8'(done0), 8'h01);
    for (int t = 0; t < 6; t++) begin
      logic [NK-1:0] inp;
      inp = 8'($urandom);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, inp);
      for (int i = 0; i < N; i++) begin
        idx = int'(inp[i*K +: K]);
        check("over_lut", 8'(out0[i]), 8'(r40[4 + i*W + 2 + idx]));
      end
    end

    // Random loads of random length interleaved with random run traffic and resets
    for (int it = 0; it < 10; it++) begin
      len = $urandom_range(10, 80);
      for (int j = 0; j < len; j++) cyc(1'b0, 1'b1, 1'($urandom), 1'($urandom), 8'($urandom));
      for (int j = 0; j < 30; j++)
        cyc(($urandom_range(0, 40) == 0), 1'b0, 1'b0, 1'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
